// File: rtl/seq_gen.sv
// Serial pattern transmitter: loads a parallel pattern over a valid/ready handshake
// and shifts it out MSB-first, repeated load_rep+1 times with optional idle gaps.
module seq_gen #(
    parameter int   MAX_LEN    = 32,
    parameter int   LEN_W      = 6,
    parameter int   REP_W      = 4,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LVL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [MAX_LEN-1:0] load_data,
    input  logic [LEN_W-1:0]   load_len,
    input  logic [REP_W-1:0]   load_rep,
    output logic               out,
    output logic               out_valid,
    output logic               frame_start,
    output logic               last,
    output logic               err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [1:0]         state_reg;
    logic [MAX_LEN-1:0] pat_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   idx_reg;
    logic [REP_W-1:0]   rep_reg;
    logic [GAP_W-1:0]   gap_reg;
    logic               ready_en_reg;
    logic               out_reg;
    logic               out_valid_reg;
    logic               frame_start_reg;
    logic               last_reg;
    logic               err_reg;

    logic               final_bit;
    logic               accept;
    logic               len_bad;
    logic [LEN_W-1:0]   load_msb;
    logic [LEN_W-1:0]   restart_msb;

    // Selects one pattern bit through a shift so the index width never has to match the pattern width.
    function automatic logic pick(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] idx);
        logic [MAX_LEN-1:0] s;
        s = pat >> idx;
        return s[0];
    endfunction

    assign final_bit   = (state_reg == SHIFT) && (idx_reg == '0) && (rep_reg == '0);
    assign load_ready  = ready_en_reg && ((state_reg == IDLE) || final_bit);
    assign accept      = load_valid && load_ready;
    assign len_bad     = (load_len == '0) || (32'(load_len) > 32'(MAX_LEN));
    assign load_msb    = load_len - LEN_W'(1);
    assign restart_msb = len_reg - LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            rep_reg         <= '0;
            gap_reg         <= '0;
            ready_en_reg    <= 1'b0;
            out_reg         <= IDLE_LVL;
            out_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            last_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            ready_en_reg    <= 1'b1;
            out_reg         <= IDLE_LVL;
            out_valid_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            last_reg        <= 1'b0;
            err_reg         <= 1'b0;
            // A load can only be accepted in IDLE or on the final bit, so it takes priority.
            if (accept) begin
                if (len_bad) begin
                    err_reg   <= 1'b1;
                    state_reg <= IDLE;
                end else begin
                    pat_reg         <= load_data;
                    len_reg         <= load_len;
                    rep_reg         <= load_rep;
                    idx_reg         <= load_msb;
                    out_reg         <= pick(load_data, load_msb);
                    out_valid_reg   <= 1'b1;
                    frame_start_reg <= 1'b1;
                    last_reg        <= (load_len == LEN_W'(1)) && (load_rep == '0);
                    state_reg       <= SHIFT;
                end
            end else begin
                case (state_reg)
                    SHIFT: begin
                        if (idx_reg != '0) begin
                            idx_reg       <= idx_reg - LEN_W'(1);
                            out_reg       <= pick(pat_reg, idx_reg - LEN_W'(1));
                            out_valid_reg <= 1'b1;
                            last_reg      <= (idx_reg == LEN_W'(1)) && (rep_reg == '0);
                        end else if (rep_reg != '0) begin
                            rep_reg <= rep_reg - REP_W'(1);
                            if (GAP_CYCLES == 0) begin
                                idx_reg         <= restart_msb;
                                out_reg         <= pick(pat_reg, restart_msb);
                                out_valid_reg   <= 1'b1;
                                frame_start_reg <= 1'b1;
                                last_reg        <= (len_reg == LEN_W'(1)) && (rep_reg == REP_W'(1));
                            end else begin
                                gap_reg   <= GAP_W'(GAP_CYCLES - 1);
                                state_reg <= GAP;
                            end
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    GAP: begin
                        if (gap_reg != '0) begin
                            gap_reg <= gap_reg - GAP_W'(1);
                        end else begin
                            idx_reg         <= restart_msb;
                            out_reg         <= pick(pat_reg, restart_msb);
                            out_valid_reg   <= 1'b1;
                            frame_start_reg <= 1'b1;
                            last_reg        <= (len_reg == LEN_W'(1)) && (rep_reg == '0);
                            state_reg       <= SHIFT;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign out         = out_reg;
    assign out_valid   = out_valid_reg;
    assign frame_start = frame_start_reg;
    assign last        = last_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: two instances (no gap and 2-cycle gap) share the stimulus,
// expected per-cycle output rows are queued when a load is driven and compared each cycle.
module tb_seq_gen;

    typedef struct packed {
        logic o;
        logic ov;
        logic fs;
        logic lst;
        logic er;
        logic rdy;
    } row_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [31:0] load_data;
    logic [5:0]  load_len;
    logic [3:0]  load_rep;
    logic        ready0, out0, ov0, fs0, last0, err0;
    logic        ready2, out2, ov2, fs2, last2, err2;

    row_t q0[$];
    row_t q2[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    seq_gen #(.MAX_LEN(32), .LEN_W(6), .REP_W(4), .GAP_CYCLES(0), .IDLE_LVL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready0),
        .load_data(load_data), .load_len(load_len), .load_rep(load_rep),
        .out(out0), .out_valid(ov0), .frame_start(fs0), .last(last0), .err(err0)
    );

    seq_gen #(.MAX_LEN(32), .LEN_W(6), .REP_W(4), .GAP_CYCLES(2), .IDLE_LVL(1'b0)) dut2 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready2),
        .load_data(load_data), .load_len(load_len), .load_rep(load_rep),
        .out(out2), .out_valid(ov2), .frame_start(fs2), .last(last2), .err(err2)
    );

    function automatic row_t mk(logic o, logic ov, logic fs, logic lst, logic er, logic rdy);
        row_t r;
        r = {o, ov, fs, lst, er, rdy};
        return r;
    endfunction

    task automatic check(string tag, row_t got, row_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed(o,ov,fs,last,err,rdy)=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic push(int g, row_t r);
        if (g == 0) q0.push_back(r);
        else        q2.push_back(r);
    endtask

    task automatic push_both(row_t r);
        push(0, r);
        push(2, r);
    endtask

    // Expected rows for a legal load, for the no-gap instance (g=0) and the 2-gap instance (g=2).
    task automatic push_frame(logic [31:0] d, int len, int rep);
        for (int g = 0; g <= 2; g += 2) begin
            for (int r = 0; r <= rep; r++) begin
                for (int i = len - 1; i >= 0; i--)
                    push(g, mk(d[i], 1'b1, i == len - 1, (r == rep) && (i == 0), 1'b0,
                               (r == rep) && (i == 0)));
                if (r < rep)
                    for (int k = 0; k < g; k++) push(g, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic step();
        row_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("gap0", {out0, ov0, fs0, last0, err0, ready0}, e);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("gap2", {out2, ov2, fs2, last2, err2, ready2}, e);
        end
    endtask

    // Pads both queues to equal length with idle rows, adds one trailing idle row, then drains.
    task automatic run();
        int n;
        while (q0.size() < q2.size()) q0.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        while (q2.size() < q0.size()) q2.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        push_both(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        n = 0;
        while ((q0.size() > 0 || q2.size() > 0) && n < 400) begin
            step();
            n++;
        end
        if (q0.size() > 0 || q2.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout cyc=%0d observed_left=%0d required_left=0", cyc, q0.size() + q2.size());
            q0.delete();
            q2.delete();
        end
    endtask

    task automatic drive(logic [31:0] d, logic [5:0] len, logic [3:0] rep);
        load_data  = d;
        load_len   = len;
        load_rep   = rep;
        load_valid = 1'b1;
    endtask

    task automatic do_frame(logic [31:0] d, int len, int rep);
        drive(d, 6'(len), 4'(rep));
        push_frame(d, len, rep);
        step();
        load_valid = 1'b0;
        load_data  = ~d;
        run();
    endtask

    task automatic do_bad_len(logic [5:0] len);
        drive(32'hFFFF_FFFF, len, 4'd0);
        push_both(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        step();
        load_valid = 1'b0;
        run();
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        load_rep   = '0;

        // Reset held for 4 cycles, then ready one cycle after release.
        for (int i = 0; i < 4; i++) begin
            push_both(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            step();
        end
        rst = 1'b0;
        push_both(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        step();

        do_frame(32'h0005_7575, 19, 0);
        do_frame(32'h0000_000D, 4, 1);
        do_frame(32'h0000_0001, 1, 0);
        do_frame(32'h8000_0001, 32, 0);
        do_frame(32'h0000_0001, 1, 15);
        do_frame(32'h0000_0005, 3, 2);
        do_bad_len(6'd0);
        do_bad_len(6'd33);

        // Back-to-back: second load presented on the final bit of the first frame.
        drive(32'h0000_000D, 6'd4, 4'd0);
        push_frame(32'h0000_000D, 4, 0);
        step();
        load_valid = 1'b0;
        load_data  = 32'h0;
        for (int i = 0; i < 3; i++) step();
        drive(32'h0000_0002, 6'd2, 4'd0);
        push_frame(32'h0000_0002, 2, 0);
        step();
        load_valid = 1'b0;
        run();

        // Mid-frame reset on the 5th bit, then a clean new frame.
        drive(32'h0005_7575, 6'd19, 4'd0);
        push_frame(32'h0005_7575, 19, 0);
        while (q0.size() > 5) q0.delete(q0.size() - 1);
        while (q2.size() > 5) q2.delete(q2.size() - 1);
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        push_both(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        rst = 1'b0;
        push_both(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        do_frame(32'h0000_000D, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial pattern transmitter that drives the single-bit serial input of the seq_detect sequence detector.
- Accepts a parallel pattern of programmable length through a valid/ready load handshake and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with optional idle gap cycles between repetitions.
- Used as the stimulus source in front of seq_detect and for on-chip pattern generation.

Parameters:
- MAX_LEN, 32, width of load_data; maximum pattern length in bits.
- LEN_W, 6, width of load_len; must hold MAX_LEN.
- REP_W, 4, width of load_rep.
- GAP_CYCLES, 0, idle cycles inserted between repetitions (0 = back-to-back).
- IDLE_LVL, 0, level driven on out when not transmitting.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load request.
- load_ready  out  1  block can accept a load this cycle.
- load_data  in  MAX_LEN  pattern; bits [load_len-1:0] are used; bit load_len-1 is sent first.
- load_len  in  LEN_W  pattern length in bits; legal range 1..MAX_LEN.
- load_rep  in  REP_W  extra repetitions; total transmissions = load_rep+1.
- out  out  1  serial data.
- out_valid  out  1  out carries a pattern bit this cycle.
- frame_start  out  1  high on the first bit of every repetition.
- last  out  1  high on the final bit of the final repetition.
- err  out  1  one-cycle pulse when an illegal length is accepted.

Behaviour:
- Reset: rst sampled high forces state IDLE.
  - out=IDLE_LVL, out_valid=0, frame_start=0, last=0, err=0, load_ready=0.
  - load_ready goes to 1 in the first cycle after rst is sampled low.
  - Reset mid-frame aborts immediately; remaining bits are dropped.
- All outputs are registered except load_ready, which is decoded combinationally from state only, never from load_valid.
- States: IDLE, SHIFT, GAP.
- IDLE: load_ready=1. On load_valid&load_ready at edge N:
  - Capture load_data, load_len and load_rep.
  - Bit load_len-1 is on out, with out_valid=1 and frame_start=1, in cycle N+1.
- SHIFT: one bit per cycle, descending index, down to bit 0.
- End of a repetition, more repetitions remaining:
  - GAP_CYCLES=0: bit load_len-1 follows the next cycle with frame_start=1.
  - GAP_CYCLES>0: enter GAP; out=IDLE_LVL and out_valid=0 for exactly GAP_CYCLES cycles, then SHIFT restarts at the MSB.
- Final bit of final repetition:
  - last=1 and load_ready=1 in the same cycle.
  - A load accepted in that cycle starts the new pattern in the very next cycle, with no bubble.
  - Otherwise return to IDLE.
- load_ready=0 in SHIFT, except on the final bit. load_ready=0 in GAP.
- load_len=1: the single bit is first and last; frame_start and last both high when it is the final repetition.
- Illegal length (load_len=0 or load_len>MAX_LEN):
  - The load is accepted and discarded; err=1 in cycle N+1.
  - No bits are sent and state stays IDLE.
- Bit counter width LEN_W; repetition counter width REP_W. No wrap: load_rep=2^REP_W-1 yields exactly 2^REP_W transmissions.
- Captured pattern is unaffected by load_data changes after acceptance.

Test Plan:
- Reset release: rst=1 for 4 cycles, then 0 -> out=0, out_valid=0, load_ready=0 during reset; load_ready=1 one cycle after release.
- Basic frame: load_data=0x57575, load_len=19, load_rep=0 ->
  - out = 1,0,1,0,1,1,1,0,1,0,1,0,1,1,1,0,1,0,1 on cycles N+1..N+19.
  - frame_start only at N+1; last only at N+19.
  - Output fed into seq_detect gives its expected match sequence.
- Repeat with gap: GAP_CYCLES=2, load_data=0b1101, load_len=4, load_rep=1 ->
  - Stream 1101, then 2 cycles out=0 with out_valid=0, then 1101.
  - frame_start high twice; last on the 10th cycle after N.
- Back-to-back: second load (0b10, len 2) presented with valid on the last bit of the first frame -> accepted that cycle; 1,0 follow with zero idle cycles.
- Illegal/edge lengths:
  - load_len=0 -> err pulse, out_valid stays 0.
  - load_len=1, data=1 -> single bit 1 with frame_start=last=1.
  - load_len=32, data=0x80000001 -> 1, 30 zeros, 1.
- Mid-frame reset: assert rst on the 5th bit of the 19-bit frame -> next cycle out=IDLE_LVL, out_valid=0; a new load after release transmits from the MSB cleanly.
